// File: rtl/ptp_bridge_dbg_pkg.sv
// rtl/ptp_bridge_dbg_pkg.sv - shared types and constants for the PTP bridge debug AVMM arbiter
package ptp_bridge_dbg_pkg;

    // Arbiter FSM: at most one downstream transaction in flight.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    // Read data returned to the requester when the downstream never answers.
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/ptp_bridge_dbg_rr_arb.sv
// rtl/ptp_bridge_dbg_rr_arb.sv - two-way round-robin grant logic
//
// Ports:
//   req[1:0]   : request per requester
//   last       : index of the requester granted most recently
//   grant[1:0] : one-hot grant (all zero when nobody requests)
module ptp_bridge_dbg_rr_arb (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // On a tie the requester that was not granted last wins.
    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0] & (~req[1] | last);
        grant[1] = req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/ptp_bridge_dbg_avmm_arb.sv
// rtl/ptp_bridge_dbg_avmm_arb.sv - two-requester AVMM arbiter with read-response timeout
//
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   m0_* / m1_*               : upstream AVMM agents (address, read, write, writedata,
//                               byteenable in; waitrequest, readdata, readdatavalid out)
//   s_*                       : shared downstream AVMM port
//   timeout_err               : one-cycle pulse per read that timed out
module ptp_bridge_dbg_avmm_arb
    import ptp_bridge_dbg_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   m0_address,
    input  logic                    m0_read,
    input  logic                    m0_write,
    input  logic [DATA_WIDTH-1:0]   m0_writedata,
    input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
    output logic                    m0_waitrequest,
    output logic [DATA_WIDTH-1:0]   m0_readdata,
    output logic                    m0_readdatavalid,

    input  logic [ADDR_WIDTH-1:0]   m1_address,
    input  logic                    m1_read,
    input  logic                    m1_write,
    input  logic [DATA_WIDTH-1:0]   m1_writedata,
    input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
    output logic                    m1_waitrequest,
    output logic [DATA_WIDTH-1:0]   m1_readdata,
    output logic                    m1_readdatavalid,

    output logic [ADDR_WIDTH-1:0]   s_address,
    output logic                    s_read,
    output logic                    s_write,
    output logic [DATA_WIDTH-1:0]   s_writedata,
    output logic [DATA_WIDTH/8-1:0] s_byteenable,
    input  logic                    s_waitrequest,
    input  logic [DATA_WIDTH-1:0]   s_readdata,
    input  logic                    s_readdatavalid,

    output logic                    timeout_err
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                  state, state_next;
    logic [1:0]              req;
    logic [1:0]              grant;
    logic                    last;
    logic                    gnt_idx;
    logic                    is_read;
    logic [15:0]             cnt;
    logic                    accept;
    logic                    timeout_hit;
    logic [DATA_WIDTH-1:0]   rsp_data;

    logic [ADDR_WIDTH-1:0]   sel_address;
    logic                    sel_read;
    logic                    sel_write;
    logic [DATA_WIDTH-1:0]   sel_writedata;
    logic [DATA_WIDTH/8-1:0] sel_byteenable;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    ptp_bridge_dbg_rr_arb u_rr_arb (
        .req   (req),
        .last  (last),
        .grant (grant)
    );

    // Command of whichever requester the arbiter picks this cycle.
    always_comb begin
        sel_address    = m0_address;
        sel_read       = m0_read;
        sel_write      = m0_write;
        sel_writedata  = m0_writedata;
        sel_byteenable = m0_byteenable;
        if (grant[1]) begin
            sel_address    = m1_address;
            sel_read       = m1_read;
            sel_write      = m1_write;
            sel_writedata  = m1_writedata;
            sel_byteenable = m1_byteenable;
        end
    end

    // The downstream accepts in the CMD cycle where it drops waitrequest;
    // the granted requester sees its own acceptance in that same cycle.
    assign accept         = (state == CMD) && !s_waitrequest;
    assign m0_waitrequest = !(accept && (gnt_idx == 1'b0));
    assign m1_waitrequest = !(accept && (gnt_idx == 1'b1));

    // Counter holds the number of completed RD_WAIT cycles, so the
    // timeout fires in the TIMEOUT_CYCLES-th RD_WAIT cycle.
    assign timeout_hit = (state == RD_WAIT) && (cnt == CNT_LAST);
    assign rsp_data    = s_readdatavalid ? s_readdata : DATA_WIDTH'(TIMEOUT_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req) state_next = CMD;
            CMD:     if (!s_waitrequest) state_next = is_read ? RD_WAIT : IDLE;
            RD_WAIT: if (s_readdatavalid || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last             <= 1'b1;
            gnt_idx          <= 1'b0;
            is_read          <= 1'b0;
            cnt              <= '0;
            s_address        <= '0;
            s_read           <= 1'b0;
            s_write          <= 1'b0;
            s_writedata      <= '0;
            s_byteenable     <= '0;
            m0_readdata      <= '0;
            m1_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
            timeout_err      <= 1'b0;
            cnt              <= (state == RD_WAIT) ? cnt + 16'd1 : 16'd0;

            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt_idx      <= grant[1];
                        last         <= grant[1];
                        s_address    <= sel_address;
                        s_writedata  <= sel_writedata;
                        s_byteenable <= sel_byteenable;
                        // A simultaneous read and write is treated as a read.
                        s_read       <= sel_read;
                        s_write      <= sel_write & ~sel_read;
                        is_read      <= sel_read;
                    end
                end
                CMD: begin
                    if (!s_waitrequest) begin
                        s_read  <= 1'b0;
                        s_write <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    // Real data wins over a timeout expiring in the same cycle.
                    if (s_readdatavalid || timeout_hit) begin
                        if (gnt_idx) begin
                            m1_readdata      <= rsp_data;
                            m1_readdatavalid <= 1'b1;
                        end else begin
                            m0_readdata      <= rsp_data;
                            m0_readdatavalid <= 1'b1;
                        end
                        timeout_err <= ~s_readdatavalid;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ptp_bridge_dbg_avmm_arb.md
PTP_BRIDGE_DBG_AVMM_ARB -- requirements
Module: ptp_bridge_dbg_avmm_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, AVMM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AVMM data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, read-response timeout in clk cycles (1..65535).
REQ-004 SHALL use one clock and an asynchronous, active-high reset. Ports: clk, input, 1, sole clock; rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL provide, for requester i in {0,1}: mi_address (in, ADDR_WIDTH), mi_read (in, 1), mi_write (in, 1), mi_writedata (in, DATA_WIDTH), mi_byteenable (in, DATA_WIDTH/8), mi_waitrequest (out, 1), mi_readdata (out, DATA_WIDTH), mi_readdatavalid (out, 1).
REQ-006 SHALL provide the shared downstream port: s_address, s_read, s_write, s_writedata, s_byteenable (out; widths as REQ-005), s_waitrequest (in, 1), s_readdata (in, DATA_WIDTH), s_readdatavalid (in, 1).
REQ-007 SHALL provide timeout_err (out, 1), a one-cycle pulse per timed-out read.

Function
REQ-008 SHALL run FSM states IDLE, CMD, RD_WAIT; one transaction outstanding at most.
REQ-009 IDLE: a request is mi_read|mi_write. With one requester, grant it; with both, grant the requester not granted last (round-robin). Then register its command onto s_* and go to CMD. s_read/s_write assert the cycle after the request is sampled.
REQ-010 CMD: hold s_* stable while s_waitrequest=1. When s_waitrequest=0, deassert s_read/s_write next cycle and drive granted mi_waitrequest=0 for exactly that accepting cycle. Write: go to IDLE. Read: go to RD_WAIT.
REQ-011 mi_waitrequest SHALL be 1 in all other cycles, including for the non-granted requester.
REQ-012 RD_WAIT: on s_readdatavalid=1, forward s_readdata to granted mi_readdata with mi_readdatavalid=1 for one cycle (registered, 1-cycle latency), then go to IDLE.
REQ-013 RD_WAIT: a counter starts at 0 on entry. When it reaches TIMEOUT_CYCLES with no s_readdatavalid: drive mi_readdata=TIMEOUT_DATA and mi_readdatavalid=1 to the granted requester, pulse timeout_err, go to IDLE. s_readdatavalid in that same cycle wins, with no timeout.
REQ-014 s_readdatavalid outside RD_WAIT SHALL be dropped and not forwarded.
REQ-015 mi_read and mi_write both set: treated as a read, write discarded.
REQ-016 A requester's command SHALL be presented downstream unchanged; the arbiter does no address decode.
REQ-017 Last-grant pointer SHALL update only when a grant is issued in IDLE.
REQ-018 Back-to-back: a new grant may be issued in the cycle IDLE is re-entered, so there is one idle cycle minimum between downstream commands.

Reset
REQ-019 On rst: FSM=IDLE; s_read=s_write=0; mi_waitrequest=1; mi_readdatavalid=0; timeout_err=0; counter=0; last-grant=1 (requester 0 wins first tie). s_address/data/byteenable and mi_readdata SHALL be 0.
REQ-020 Reset mid-transaction SHALL abandon it with no readdatavalid issued. A response arriving after reset is dropped per REQ-014.

Structure
REQ-021 Package ptp_bridge_dbg_pkg SHALL hold the state enum and TIMEOUT_DATA = 32'hDEAD_BEEF.
REQ-022 The 2-way round-robin grant logic (req[1:0], last, grant[1:0]) SHALL be sub-module ptp_bridge_dbg_rr_arb.

Verification
REQ-023 m0 write addr 'h8218 data 'h1234_5678, s_waitrequest low. Required: s_write=1 one cycle, m0_waitrequest low one cycle, m1 untouched.
REQ-024 m0 and m1 read together in IDLE after reset. Required: m0 served first, then m1; repeat the dual request and m0 is served again first (alternation).
REQ-025 m1 read, s_waitrequest held 3 cycles, s_readdatavalid 2 cycles after accept with 'hCAFE_0001. Required: s_* stable 4 cycles, m1_readdata='hCAFE_0001 with m1_readdatavalid one cycle.
REQ-026 m0 read, no s_readdatavalid, TIMEOUT_CYCLES=8. Required: after 8 RD_WAIT cycles, m0_readdata='hDEAD_BEEF with readdatavalid, timeout_err pulse, FSM IDLE.
REQ-027 rst asserted in RD_WAIT, then late s_readdatavalid. Required: no mi_readdatavalid, all outputs at REQ-019 values.
REQ-028 s_readdatavalid in the same cycle the timeout expires. Required: real data forwarded, timeout_err stays 0.
